mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory-port arbiter for the single-ported unified instruction/data memory of the core. It sits between the memory and two requesters: the fetch path (driven by the control FSM's fetch states) and the data load/store path (driven by the execute/memory-access states). It serialises their accesses, alternates between them on conflict, and hides the memory's fixed read latency behind a req/ack handshake.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LATENCY`, 1, cycles from strobe to valid `mem_rdata`; legal range 1..15

- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `if_req` in 1: fetch read request, level, held until `if_ack`.
- `if_addr` in ADDR_W: fetch address.
- `if_ack` out 1: one-cycle completion pulse for fetch.
- `if_rdata` out DATA_W: fetched word, registered.
- `dm_req` in 1: data request, level, held until `dm_ack`.
- `dm_we` in 1: 1 = write, 0 = read.
- `dm_addr` in ADDR_W: data address.
- `dm_wdata` in DATA_W: write data.
- `dm_ack` out 1: one-cycle completion pulse for data.
- `dm_rdata` out DATA_W: loaded word, registered.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rden` out 1: memory read strobe.
- `mem_wren` out 1: memory write strobe.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. A 4-bit wait counter and a `last_grant` flag (IF/DM) are held alongside the state.
- **IDLE**
  - Only one req high: grant it.
  - Both high: grant the requester that is not `last_grant`.
  - On grant, latch the owner, address, `dm_we` (forced to 0 for IF) and `dm_wdata` into registers, update `last_grant`, load the counter with MEM_LATENCY, and go to ISSUE.
  - No req: stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - `mem_rden = ~we` or `mem_wren = we` is high.
  - `mem_addr` and `mem_wdata` are driven from the latched registers.
  - Next state: WAIT.
- **WAIT**
  - Lasts MEM_LATENCY cycles; the counter decrements each cycle.
  - On the edge where the counter reaches 1, for a read, capture `mem_rdata` into the owner's rdata register, then go to DONE.
  - Writes also wait the full latency.
- **DONE** (exactly 1 cycle)
  - The owner's ack is high.
  - Next state: IDLE unconditionally.
  - Requests are not evaluated in DONE.
- Handshake rules:
  - A requester drops req in the cycle after ack.
  - Req still high in the following IDLE is a new request.
  - Req dropped before grant means no transaction.
  - Req dropped after grant: the transaction completes and ack still pulses.
  - Input changes after grant are ignored.
- Read data:
  - `if_rdata` and `dm_rdata` hold their value until the next completed read by the same owner.
  - Writes leave `dm_rdata` unchanged.
- Strobes and acks are decoded from the state register only, never from inputs.
- `mem_addr` and `mem_wdata` show the latched registers in all states.

## Timing
- Reset values:
  - state IDLE, counter 0, `last_grant` = IF (so DM wins the first conflict).
  - All latched registers, `if_rdata` and `dm_rdata` are 0.
  - Therefore all outputs are 0.
- Latency:
  - Req sampled high in IDLE at cycle 0 → ISSUE at cycle 1 → WAIT at cycles 2..1+MEM_LATENCY → ack at cycle 2+MEM_LATENCY.
  - With default MEM_LATENCY=1, ack is at cycle 3.
- Throughput: one transaction per MEM_LATENCY+3 cycles (DONE→IDLE costs one cycle).
- Reset mid-transaction (any non-IDLE state):
  - Strobes and acks fall immediately (asynchronous).
  - The transaction is aborted and no ack is issued.
  - rdata registers clear to 0.
- Both req high continuously: grants alternate DM, IF, DM, IF…; neither requester waits more than one other transaction.

## Test plan
- Reset then `if_req`=1, `if_addr`=0x100, mem returns 0xDEADBEEF → `mem_rden` high at cycle 1 with `mem_addr`=0x100, `if_ack` at cycle 3, `if_rdata`=0xDEADBEEF; `mem_wren` never high.
- `dm_req`=1, `dm_we`=1, `dm_addr`=0x200, `dm_wdata`=0x12345678 → `mem_wren` 1 cycle with those values, `dm_ack` at cycle 3, `dm_rdata` unchanged.
- Both reqs held high from reset, each dropped for one cycle after its ack → grant order DM, IF, DM, IF; acks 4 cycles apart.
- MEM_LATENCY=4 build, IF read → `if_ack` at cycle 6; `mem_rdata` presented only at cycle 5 is captured correctly.
- `reset` asserted mid-WAIT of a DM read → `busy`, strobes and `dm_ack` go 0 without a clock edge; `dm_rdata`=0; the next request completes normally.
- Change `dm_addr` 0x200→0x300 during WAIT, or drop `dm_req` after grant → `mem_addr` stays 0x200 and `dm_ack` still pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-ported unified memory: serialises fetch
// and data accesses, alternates owners on conflict, and waits out the memory's fixed read latency.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_dm_q, last_dm_d;   // 0 = IF granted last, so DM wins next conflict
  logic              own_dm_q, own_dm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm, grant_if;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_dm_q  <= 1'b0;
      own_dm_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dm_q  <= last_dm_d;
      own_dm_q   <= own_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dm_d  = last_dm_q;
    own_dm_d   = own_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_dm   = dm_req & (~if_req | ~last_dm_q);
    grant_if   = if_req & ~grant_dm;
    unique case (state_q)
      S_IDLE: begin
        if (grant_dm | grant_if) begin
          own_dm_d  = grant_dm;
          last_dm_d = grant_dm;
          addr_d    = grant_dm ? dm_addr : if_addr;
          we_d      = grant_dm & dm_we;
          wdata_d   = dm_wdata;
          cnt_d     = LAT;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Counter hitting 1 marks the cycle the memory's read data is valid
        if (cnt_q <= 4'd1) begin
          if (!we_q) begin
            if (own_dm_q) dm_rdata_d = mem_rdata;
            else          if_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rden  = (state_q == S_ISSUE) & ~we_q;
  assign mem_wren  = (state_q == S_ISSUE) &  we_q;
  assign if_ack    = (state_q == S_DONE)  & ~own_dm_q;
  assign dm_ack    = (state_q == S_DONE)  &  own_dm_q;
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-1 instance for most scenarios and a
// latency-4 instance for the long-latency read.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_rden, mem_wren, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  logic        if_req4;
  logic [31:0] if_addr4, mem_rdata4;
  logic        if_ack4, dm_ack4, mem_rden4, mem_wren4, busy4;
  logic [31:0] if_rdata4, dm_rdata4, mem_addr4, mem_wdata4;

  int checks = 0;
  int failures = 0;
  int wren_cnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) if (mem_wren) wren_cnt <= wren_cnt + 1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .if_req(if_req4), .if_addr(if_addr4), .if_ack(if_ack4), .if_rdata(if_rdata4),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_ack(dm_ack4), .dm_rdata(dm_rdata4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rden(mem_rden4), .mem_wren(mem_wren4),
    .mem_rdata(mem_rdata4), .busy(busy4));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    if_req4 = 0; if_addr4 = 0; mem_rdata4 = 0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if ({busy, if_ack, dm_ack, mem_rden, mem_wren} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, if_ack, dm_ack, mem_rden, mem_wren});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      failures++; $display("FAIL reset_data got=%h %h %h %h exp=0", mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
  endtask

  task automatic test_if_read();
    int w0 = wren_cnt;
    if_addr = 32'h100; if_req = 1;                       // cycle 0
    cyc();                                               // cycle 1
    checks++;
    if (mem_rden !== 1'b1 || mem_addr !== 32'h100) begin
      failures++; $display("FAIL if_issue got rden=%b addr=%h exp rden=1 addr=100", mem_rden, mem_addr);
    end
    mem_rdata = 32'hDEADBEEF;
    cyc();                                               // cycle 2
    checks++;
    if (if_ack !== 1'b0 || mem_rden !== 1'b0) begin
      failures++; $display("FAIL if_wait got ack=%b rden=%b exp 0 0", if_ack, mem_rden);
    end
    cyc();                                               // cycle 3
    checks++;
    if (if_ack !== 1'b1 || dm_ack !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL if_done got ack=%b dmack=%b data=%h exp 1 0 deadbeef", if_ack, dm_ack, if_rdata);
    end
    if_req = 0; mem_rdata = 0;
    cyc();
    checks++;
    if (if_ack !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'hDEADBEEF || wren_cnt != w0) begin
      failures++; $display("FAIL if_after got ack=%b busy=%b data=%h wr=%0d exp 0 0 deadbeef %0d",
                           if_ack, busy, if_rdata, wren_cnt, w0);
    end
  endtask

  task automatic test_addr_hold();
    dm_addr = 32'h200; dm_we = 0; dm_req = 1;            // cycle 0
    cyc();                                               // cycle 1
    checks++;
    if (mem_rden !== 1'b1 || mem_addr !== 32'h200) begin
      failures++; $display("FAIL hold_issue got rden=%b addr=%h exp 1 200", mem_rden, mem_addr);
    end
    dm_addr = 32'h300; dm_req = 0; mem_rdata = 32'h55AA0001;
    cyc();                                               // cycle 2
    checks++;
    if (mem_addr !== 32'h200 || busy !== 1'b1) begin
      failures++; $display("FAIL hold_wait got addr=%h busy=%b exp 200 1", mem_addr, busy);
    end
    cyc();                                               // cycle 3
    checks++;
    if (dm_ack !== 1'b1 || mem_addr !== 32'h200 || dm_rdata !== 32'h55AA0001) begin
      failures++; $display("FAIL hold_done got ack=%b addr=%h data=%h exp 1 200 55aa0001", dm_ack, mem_addr, dm_rdata);
    end
    mem_rdata = 0;
    cyc();
    checks++;
    if (dm_ack !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL hold_idle got ack=%b busy=%b exp 0 0 (dropped req must not regrant)", dm_ack, busy);
    end
  endtask

  task automatic test_dm_write();
    int w0 = wren_cnt;
    dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h12345678; dm_req = 1;
    cyc();                                               // cycle 1
    checks++;
    if (mem_wren !== 1'b1 || mem_rden !== 1'b0 || mem_addr !== 32'h200 || mem_wdata !== 32'h12345678) begin
      failures++; $display("FAIL wr_issue got wren=%b rden=%b addr=%h wdata=%h exp 1 0 200 12345678",
                           mem_wren, mem_rden, mem_addr, mem_wdata);
    end
    mem_rdata = 32'hFFFFFFFF;
    cyc();                                               // cycle 2
    checks++;
    if (mem_wren !== 1'b0 || dm_ack !== 1'b0) begin
      failures++; $display("FAIL wr_wait got wren=%b ack=%b exp 0 0", mem_wren, dm_ack);
    end
    cyc();                                               // cycle 3
    checks++;
    if (dm_ack !== 1'b1 || dm_rdata !== 32'h55AA0001) begin
      failures++; $display("FAIL wr_done got ack=%b rdata=%h exp 1 55aa0001", dm_ack, dm_rdata);
    end
    dm_req = 0; dm_we = 0; mem_rdata = 0;
    cyc();
    checks++;
    if (wren_cnt != w0 + 1) begin
      failures++; $display("FAIL wr_count got=%0d exp=%0d", wren_cnt - w0, 1);
    end
  endtask

  task automatic test_back_to_back();
    int  ack_cyc[$];
    bit  ack_dm[$];
    int  exp_cyc[4] = '{3, 7, 11, 15};
    bit  exp_dm[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    reset = 1; #2; reset = 0;
    cyc();
    if_addr = 32'h400; dm_addr = 32'h500; dm_we = 0;
    if_req = 1; dm_req = 1;                              // cycle 0
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if_req = 1; dm_req = 1;
      if (dm_ack) begin ack_cyc.push_back(c); ack_dm.push_back(1'b1); dm_req = 0; end
      if (if_ack) begin ack_cyc.push_back(c); ack_dm.push_back(1'b0); if_req = 0; end
    end
    if_req = 0; dm_req = 0;
    cyc(); cyc(); cyc(); cyc();
    checks++;
    if (ack_cyc.size() != 4) begin
      failures++; $display("FAIL b2b_count got=%0d exp=4", ack_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ack_cyc[i] != exp_cyc[i] || ack_dm[i] != exp_dm[i]) begin
          failures++; $display("FAIL b2b_ack%0d got cyc=%0d dm=%0b exp cyc=%0d dm=%0b",
                               i, ack_cyc[i], ack_dm[i], exp_cyc[i], exp_dm[i]);
        end
      end
    end
  endtask

  task automatic test_latency4();
    if_addr4 = 32'h40; if_req4 = 1; mem_rdata4 = 0;      // cycle 0
    for (int c = 1; c <= 6; c++) begin
      cyc();
      mem_rdata4 = (c == 5) ? 32'hCAFEF00D : 32'h0;
      if (c == 1) begin
        checks++;
        if (mem_rden4 !== 1'b1 || mem_addr4 !== 32'h40) begin
          failures++; $display("FAIL lat4_issue got rden=%b addr=%h exp 1 40", mem_rden4, mem_addr4);
        end
      end else if (c < 6) begin
        checks++;
        if (if_ack4 !== 1'b0 || busy4 !== 1'b1) begin
          failures++; $display("FAIL lat4_wait%0d got ack=%b busy=%b exp 0 1", c, if_ack4, busy4);
        end
      end else begin
        checks++;
        if (if_ack4 !== 1'b1 || if_rdata4 !== 32'hCAFEF00D) begin
          failures++; $display("FAIL lat4_done got ack=%b data=%h exp 1 cafef00d", if_ack4, if_rdata4);
        end
        if_req4 = 0;
      end
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    dm_addr = 32'h10; dm_we = 0; dm_req = 1;
    cyc(); mem_rdata = 32'h77; dm_req = 0;
    cyc(); cyc();
    checks++;
    if (dm_ack !== 1'b1 || dm_rdata !== 32'h77) begin
      failures++; $display("FAIL rmid_pre got ack=%b data=%h exp 1 77", dm_ack, dm_rdata);
    end
    cyc();
    dm_addr = 32'h20; dm_req = 1;                        // cycle 0
    cyc(); cyc();                                        // cycle 2: WAIT
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rmid_busy got=%b exp=1", busy);
    end
    #1 reset = 1;
    #1;
    checks++;
    if ({busy, mem_rden, mem_wren, dm_ack, if_ack} !== 5'b0 || dm_rdata !== 32'h0 || mem_addr !== 32'h0) begin
      failures++; $display("FAIL rmid_async got ctrl=%b rdata=%h addr=%h exp 00000 0 0",
                           {busy, mem_rden, mem_wren, dm_ack, if_ack}, dm_rdata, mem_addr);
    end
    dm_req = 0;
    cyc();
    reset = 0;
    cyc();
    checks++;
    if (dm_ack !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rmid_noack got ack=%b busy=%b exp 0 0", dm_ack, busy);
    end
    if_addr = 32'h300; if_req = 1; mem_rdata = 32'h31415926;
    cyc(); cyc(); cyc();                                 // cycle 3
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h31415926) begin
      failures++; $display("FAIL rmid_next got ack=%b data=%h exp 1 31415926", if_ack, if_rdata);
    end
    if_req = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_addr_hold();
    test_dm_write();
    test_back_to_back();
    test_latency4();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout exp finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
